hh_spike_detector: RTL and testbench
====================================

HH_SPIKE_DETECTOR -- requirements
Module: hh_spike_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 14, meaning membrane-voltage width (two's complement Q9.5).
REQ-002 SHALL have parameter V_TH, default 14'b000000000_00000 (0.0 mV), meaning spike threshold.
REQ-003 SHALL have parameter V_REARM, default 14'b111011000_00000 (-40.0 mV), meaning re-arm level; V_REARM < V_TH is required.
REQ-004 SHALL have parameter REFRAC, default 8, meaning refractory length in valid samples.
REQ-005 SHALL have parameter ISI_W, default 16, meaning interval and count width.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 v_in  input  WIDTH  membrane voltage sample from the neuron core, signed Q9.5.
REQ-009 v_valid  input  1  v_in is a new sample this cycle.
REQ-010 spike  output  1  one-cycle spike pulse.
REQ-011 spike_count  output  ISI_W  saturating spike count since reset.
REQ-012 isi_data  output  ISI_W  inter-spike interval in valid samples.
REQ-013 isi_valid  output  1  isi_data holds an unconsumed interval.
REQ-014 isi_ready  input  1  consumer accepts isi_data this cycle.
REQ-015 overrun  output  1  sticky flag: an interval was dropped.
REQ-016 armed  output  1  high in state ARMED.

Function
REQ-017 All comparisons on v_in SHALL be signed; only cycles with v_valid=1 SHALL advance the FSM, the counters or the interval counter.
REQ-018 FSM states SHALL be ARMED, REFRACT and WAIT_REARM.
REQ-019 ARMED, valid sample with v_in >= V_TH: this is a spike sample; next state REFRACT with refractory counter loaded to REFRAC, or WAIT_REARM if REFRAC=0.
REQ-020 REFRACT, valid sample: if counter <= 1, go to WAIT_REARM; else decrement the counter. Samples >= V_TH in this state SHALL NOT cause a spike.
REQ-021 WAIT_REARM, valid sample with v_in <= V_REARM: go to ARMED; that sample SHALL NOT itself spike.
REQ-022 spike SHALL be registered, high exactly in the cycle after the spike sample's edge (latency 1), and low otherwise.
REQ-023 spike_count SHALL increment by 1 per spike and saturate at 2^ISI_W-1.
REQ-024 Interval counter behaviour: non-spike valid samples increment it, saturating. On a spike sample, the captured interval SHALL be counter+1 (saturating) and the counter SHALL clear to 0.
REQ-025 The first spike after reset SHALL NOT produce an interval; it only starts the counter. Each later spike SHALL produce one interval.
REQ-026 Output handshake: a transfer occurs when isi_valid=1 and isi_ready=1 at a rising edge. isi_data SHALL remain stable while isi_valid=1 and no transfer occurs.
REQ-027 A new interval SHALL be loaded with isi_valid=1 on the same edge as its spike sample, if the buffer is empty or is being transferred that edge; no overrun results in that case.
REQ-028 A new interval arriving while isi_valid=1 and isi_ready=0 SHALL be dropped: the old isi_data is kept and overrun is set to 1 until reset.
REQ-029 isi_valid SHALL clear after a transfer unless a new interval loads on the same edge.

Reset
REQ-030 While rst=1: state=WAIT_REARM, spike=0, spike_count=0, isi_data=0, isi_valid=0, overrun=0, armed=0, interval and refractory counters=0, and the first-spike flag cleared.
REQ-031 Assertion mid-refractory or mid-handshake SHALL discard all pending state immediately; after deassertion no spike is possible until a sample <= V_REARM has been seen.

Verification
REQ-032 Reset, then samples -65, -65, +10 mV -> sample 1 arms; spike pulses one cycle after sample 3; spike_count=1; isi_valid stays 0.
REQ-033 Spike samples at valid-sample indices 10 and 25, REFRAC=8, voltage dropping to -65 between them, isi_ready=1 -> isi_data=15 with isi_valid high 1 cycle; spike_count=2.
REQ-034 +10 mV held for 20 samples after a spike -> exactly one spike, no re-trigger; armed stays 0 until a sample of -40 mV or below arrives.
REQ-035 isi_ready=0 across three spikes -> first interval held stable; overrun=1 after the third spike; asserting isi_ready then gives one transfer of the first interval.
REQ-036 Transfer and new interval on the same edge -> the new interval is loaded, isi_valid stays 1, overrun stays 0.
REQ-037 rst pulsed during REFRACT with isi_valid=1 -> all outputs zero asynchronously; a +10 mV sample right after reset gives no spike.

Source files
------------

// File: rtl/hh_spike_detector.sv
// Spike detector for a Hodgkin-Huxley membrane-voltage stream: threshold
// crossing with refractory period and hysteresis re-arm, plus spike counting
// and an inter-spike-interval (ISI) output buffer.
// Latency: spike pulses 1 cycle after the spike sample's edge; a new ISI is
// presented on that same edge.
// Backpressure: one-entry ISI buffer (isi_valid/isi_ready); an interval that
// arrives while the buffer is full and not draining is dropped and sets the
// sticky overrun flag.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   v_in, v_valid         signed Q9.5 voltage sample and its strobe
//   spike                 one-cycle registered spike pulse
//   spike_count           saturating spike count since reset
//   isi_data, isi_valid   interval in valid samples, with valid flag
//   isi_ready             consumer accepts isi_data
//   overrun               sticky: an interval was dropped
//   armed                 detector is ready to fire
module hh_spike_detector #(
  parameter int                      WIDTH   = 14,
  parameter logic signed [WIDTH-1:0] V_TH    = 14'b000000000_00000,
  parameter logic signed [WIDTH-1:0] V_REARM = 14'b111011000_00000,
  parameter int                      REFRAC  = 8,
  parameter int                      ISI_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v_in,
  input  logic             v_valid,
  output logic             spike,
  output logic [ISI_W-1:0] spike_count,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic             overrun,
  output logic             armed
);

  localparam int RC_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  localparam logic [ISI_W-1:0] CNT_MAX = {ISI_W{1'b1}};

  typedef enum logic [1:0] {ARMED, REFRACT, WAIT_REARM} state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [ISI_W-1:0]  ivl_q, ivl_d;
  logic              seen_q, seen_d;
  logic              spike_q, spike_d;
  logic [ISI_W-1:0]  cnt_q, cnt_d;
  logic [ISI_W-1:0]  isi_dat_q, isi_dat_d;
  logic              isi_vld_q, isi_vld_d;
  logic              ovr_q, ovr_d;

  logic signed [WIDTH-1:0] vs;
  logic                    spike_smp;
  logic [ISI_W-1:0]        ivl_inc;

  assign vs      = $signed(v_in);
  // Saturating "counter + 1": the interval includes the spike sample itself.
  assign ivl_inc = (ivl_q == CNT_MAX) ? CNT_MAX : ivl_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    ivl_d     = ivl_q;
    seen_d    = seen_q;
    spike_d   = 1'b0;
    cnt_d     = cnt_q;
    isi_dat_d = isi_dat_q;
    isi_vld_d = isi_vld_q;
    ovr_d     = ovr_q;
    spike_smp = 1'b0;

    if (v_valid) begin
      case (state_q)
        ARMED: begin
          if (vs >= V_TH) begin
            spike_smp = 1'b1;
            if (REFRAC == 0) begin
              state_d = WAIT_REARM;
            end else begin
              state_d = REFRACT;
              rc_d    = RC_W'(REFRAC);
            end
          end
        end
        REFRACT: begin
          if (rc_q <= RC_W'(1)) state_d = WAIT_REARM;
          else                  rc_d    = rc_q - 1'b1;
        end
        WAIT_REARM: begin
          // Hysteresis: only a clearly repolarised sample re-arms, and that
          // sample is never itself a spike.
          if (vs <= V_REARM) state_d = ARMED;
        end
        default: state_d = WAIT_REARM;
      endcase

      if (spike_smp) ivl_d = '0;
      else           ivl_d = ivl_inc;
    end

    if (isi_vld_q && isi_ready) isi_vld_d = 1'b0;

    if (spike_smp) begin
      spike_d = 1'b1;
      seen_d  = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      // The first spike only starts the interval counter.
      if (seen_q) begin
        if (!isi_vld_q || isi_ready) begin
          isi_dat_d = ivl_inc;
          isi_vld_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_REARM;
      rc_q      <= '0;
      ivl_q     <= '0;
      seen_q    <= 1'b0;
      spike_q   <= 1'b0;
      cnt_q     <= '0;
      isi_dat_q <= '0;
      isi_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      ivl_q     <= ivl_d;
      seen_q    <= seen_d;
      spike_q   <= spike_d;
      cnt_q     <= cnt_d;
      isi_dat_q <= isi_dat_d;
      isi_vld_q <= isi_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = cnt_q;
  assign isi_data    = isi_dat_q;
  assign isi_valid   = isi_vld_q;
  assign overrun     = ovr_q;
  assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_hh_spike_detector.sv
// Bench for hh_spike_detector: directed scenarios followed by random
// stimulus, all checked each cycle against an index-based reference model
// (spikes, refractory window and intervals derived from sample indices).
module tb_hh_spike_detector;

  localparam int REFRAC  = 8;
  localparam int TH_I    = 0;        // 0.0 mV in Q9.5
  localparam int REARM_I = -40 * 32; // -40.0 mV in Q9.5
  localparam int SAT     = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] v_in;
  logic        v_valid;
  logic        spike;
  logic [15:0] spike_count;
  logic [15:0] isi_data;
  logic        isi_valid;
  logic        isi_ready;
  logic        overrun;
  logic        armed;

  hh_spike_detector dut (
    .clk         (clk),
    .rst         (rst),
    .v_in        (v_in),
    .v_valid     (v_valid),
    .spike       (spike),
    .spike_count (spike_count),
    .isi_data    (isi_data),
    .isi_valid   (isi_valid),
    .isi_ready   (isi_ready),
    .overrun     (overrun),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state
  longint idx;       // valid-sample index since reset
  longint last_spk;  // index of most recent spike sample
  bit     m_seen;    // a spike has occurred since reset
  bit     m_armed;
  bit     m_spike;
  int     m_cnt;
  int     m_dat;
  bit     m_vld;
  bit     m_ovr;

  function automatic int mv(input int m);
    return m * 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("spike",       {31'd0, spike},       {31'd0, m_spike});
    chk("spike_count", {16'd0, spike_count}, m_cnt);
    chk("isi_valid",   {31'd0, isi_valid},   {31'd0, m_vld});
    chk("isi_data",    {16'd0, isi_data},    m_dat);
    chk("overrun",     {31'd0, overrun},     {31'd0, m_ovr});
    chk("armed",       {31'd0, armed},       {31'd0, m_armed});
  endtask

  task automatic model_reset();
    idx = 0; last_spk = 0; m_seen = 0; m_armed = 0; m_spike = 0;
    m_cnt = 0; m_dat = 0; m_vld = 0; m_ovr = 0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    v_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    chk_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock with the given sample; model updated at the edge, DUT checked 1 after.
  task automatic step(input int mv32, input bit vld, input bit rdy);
    bit     sp;
    bit     xfer;
    longint ivl;
    v_in      = mv32[13:0];
    v_valid   = vld;
    isi_ready = rdy;
    @(posedge clk);
    sp      = 0;
    xfer    = m_vld && rdy;
    m_spike = 0;
    if (xfer) m_vld = 0;
    if (vld) begin
      idx++;
      if (m_armed && mv32 >= TH_I) sp = 1;
      else if (!m_armed && (!m_seen || idx - last_spk > REFRAC) && mv32 <= REARM_I)
        m_armed = 1;
      if (sp) begin
        m_armed = 0;
        m_spike = 1;
        if (m_cnt < SAT) m_cnt++;
        if (m_seen) begin
          ivl = idx - last_spk;
          if (ivl > SAT) ivl = SAT;
          if (!m_vld) begin
            m_dat = int'(ivl);
            m_vld = 1;
          end else begin
            m_ovr = 1;
          end
        end
        m_seen   = 1;
        last_spk = idx;
      end
    end
    #1;
    chk_all();
  endtask

  task automatic run(input int mv32, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(mv32, 1'b1, rdy);
  endtask

  initial begin
    rst = 1'b0; v_in = '0; v_valid = 1'b0; isi_ready = 1'b0;
    #1;
    do_reset();

    // Arm, then fire on the third sample.
    step(mv(-65), 1, 1);
    chk("arm_after_first", {31'd0, armed}, 32'd1);
    step(mv(-65), 1, 1);
    step(mv(10), 1, 1);
    chk("first_spike", {31'd0, spike}, 32'd1);
    chk("first_count", {16'd0, spike_count}, 32'd1);
    chk("first_no_isi", {31'd0, isi_valid}, 32'd0);
    step(mv(10), 1, 1);
    chk("spike_one_cycle", {31'd0, spike}, 32'd0);

    // Spikes at sample indices 10 and 25 give an interval of 15.
    do_reset();
    run(mv(-65), 9, 1);
    step(mv(10), 1, 1);
    run(mv(-65), 14, 1);
    step(mv(10), 1, 1);
    chk("isi15_data", {16'd0, isi_data}, 32'd15);
    chk("isi15_valid", {31'd0, isi_valid}, 32'd1);
    chk("isi15_count", {16'd0, spike_count}, 32'd2);
    step(mv(-65), 1, 1);
    chk("isi15_drained", {31'd0, isi_valid}, 32'd0);

    // Held above threshold: no re-trigger; re-arm boundary at exactly -40 mV.
    do_reset();
    step(mv(-65), 1, 1);
    step(mv(10), 1, 1);
    run(mv(10), 20, 1);
    chk("held_count", {16'd0, spike_count}, 32'd1);
    step(mv(-39), 1, 1);
    chk("no_rearm_m39", {31'd0, armed}, 32'd0);
    step(REARM_I, 1, 1);
    chk("rearm_m40", {31'd0, armed}, 32'd1);
    step(-1, 1, 1);
    chk("below_th_no_spike", {31'd0, spike}, 32'd0);
    step(TH_I, 1, 1);
    chk("at_th_spike", {31'd0, spike}, 32'd1);
    step(1, 1, 1); // invalid-gap checks below
    step(mv(-65), 0, 1);
    step(mv(10), 0, 1);

    // Three spikes with no consumer: first interval held, later one dropped.
    do_reset();
    step(mv(-65), 1, 0);
    step(mv(10), 1, 0);
    run(mv(-65), 9, 0);
    step(mv(10), 1, 0);
    run(mv(-65), 12, 0);
    step(mv(10), 1, 0);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_held_data", {16'd0, isi_data}, 32'd10);
    step(mv(-65), 1, 1);
    chk("ovr_drained", {31'd0, isi_valid}, 32'd0);
    step(mv(-65), 1, 1);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Transfer and new interval on the same edge.
    do_reset();
    step(mv(-65), 1, 0);
    step(mv(10), 1, 0);
    run(mv(-65), 9, 0);
    step(mv(10), 1, 0);
    run(mv(-65), 10, 0);
    step(mv(10), 1, 1);
    chk("same_edge_valid", {31'd0, isi_valid}, 32'd1);
    chk("same_edge_data", {16'd0, isi_data}, 32'd11);
    chk("same_edge_no_ovr", {31'd0, overrun}, 32'd0);

    // Reset during refractory with a pending interval.
    do_reset();
    step(mv(-65), 1, 0);
    step(mv(10), 1, 0);
    run(mv(-65), 9, 0);
    step(mv(10), 1, 0);
    step(mv(-65), 1, 0);
    do_reset();
    step(mv(10), 1, 1);
    chk("post_reset_no_spike", {31'd0, spike}, 32'd0);
    step(mv(10), 1, 1);
    chk("post_reset_not_armed", {31'd0, armed}, 32'd0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int sel;
      int v;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      v = TH_I;
      else if (sel == 1) v = REARM_I;
      else               v = mv(int'($urandom_range(0, 110)) - 80) + int'($urandom_range(0, 31));
      if ($urandom_range(0, 599) == 0) do_reset();
      step(v, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
